// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master state encoding and address-map constants.
package apb_pkg;
    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_ERROR} apb_state_e;
    localparam logic [15:0] APB_BASE_HI = 16'h1000;
    localparam int APB_WIN_BITS = 12;  // 4 KB window per slave
    localparam int MAX_SLAVES = 16;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: APB3 bus between one master and NUM_SLAVES peripheral slaves.
interface apb_master_if #(parameter int NUM_SLAVES = 4);
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic PWRITE;
    logic PENABLE;
    logic [NUM_SLAVES-1:0] PSEL;
    logic [NUM_SLAVES-1:0] PREADY;
    logic [NUM_SLAVES*32-1:0] PRDATA;
    modport master(output PADDR, PWDATA, PWRITE, PENABLE, PSEL, input PRDATA, PREADY);
    modport slave(input PADDR, PWDATA, PWRITE, PENABLE, PSEL, output PRDATA, PREADY);
endinterface

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a byte address onto a peripheral window index.
module apb_addr_decoder import apb_pkg::*; #(
    parameter int NUM_SLAVES = 4
) (
    input  logic [31:0] addr,
    output logic        mapped,
    output logic [3:0]  idx
);
    localparam int NS = NUM_SLAVES > MAX_SLAVES ? MAX_SLAVES : NUM_SLAVES;
    logic unused_low;
    assign idx = addr[APB_WIN_BITS +: 4];
    assign mapped = addr[31:16] == APB_BASE_HI && 32'(idx) < NS;
    assign unused_low = ^addr[APB_WIN_BITS-1:0];
endmodule

// File: rtl/apb_master.sv
// apb_master: CPU transfer/ready handshake to APB3 SETUP/ACCESS sequencing.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES with an error completion.
module apb_master import apb_pkg::*; #(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        slvErr,
    apb_master_if.master apb
);
    localparam logic [1:0] IDLE   = APB_IDLE;
    localparam logic [1:0] SETUP  = APB_SETUP;
    localparam logic [1:0] ACCESS = APB_ACCESS;
    localparam logic [1:0] ERROR  = APB_ERROR;

    logic [1:0] state, state_n;
    logic [3:0] idx, dec_idx;
    logic mapped, prdy, done, to;
    logic [NUM_SLAVES-1:0] sel;
    logic [31:0] prd;

    apb_addr_decoder #(.NUM_SLAVES(NUM_SLAVES)) u_dec (.addr(addr), .mapped(mapped), .idx(dec_idx));

    assign sel  = NUM_SLAVES'(1) << idx;
    assign prd  = 32'(apb.PRDATA >> (32 * idx));
    assign prdy = |(apb.PREADY & sel);
    assign done = state == ACCESS && prdy;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // held at zero outside ACCESS so every ACCESS phase starts counting afresh
    always_ff @(posedge clk)
        cnt <= (reset || state != ACCESS) ? '0 : cnt + CW'(!prdy);
    assign to = state == ACCESS && !prdy && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign to = 1'b0;
`endif

    assign ready       = done || to || state == ERROR;
    assign slvErr      = to || state == ERROR;
    assign apb.PSEL    = (state == SETUP || state == ACCESS) ? sel : '0;
    assign apb.PENABLE = state == ACCESS;

    always_comb begin
        state_n = state == IDLE   ? (transfer ? (mapped ? SETUP : ERROR) : IDLE) :
                  state == SETUP  ? ACCESS :
                  state == ACCESS ? (ready ? IDLE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            apb.PADDR  <= '0;
            apb.PWDATA <= '0;
            apb.PWRITE <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && transfer) begin
                apb.PADDR  <= addr;
                apb.PWDATA <= wdata;
                apb.PWRITE <= write;
                idx        <= dec_idx;
            end
            if (state == ERROR || to)
                rdata <= '0;
            else if (done && !apb.PWRITE)
                rdata <= prd;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master with a wait-state slave model.
module tb_apb_master;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic transfer = 1'b0;
    logic write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic ready, slvErr;

    apb_master_if #(.NUM_SLAVES(NS)) apb();

    apb_master #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .slvErr(slvErr), .apb(apb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // slave model: selected slave holds PREADY low for `waits` ACCESS cycles,
    // unselected slaves sit at PREADY=1 so a decode slip is visible
    int waits = 0;
    int acc = 0;
    logic [31:0] prd [NS];
    always @(posedge clk) acc <= (apb.PENABLE && !ready) ? acc + 1 : 0;
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            apb.PREADY[i] = apb.PSEL[i] ? (apb.PENABLE && acc >= waits) : 1'b1;
            apb.PRDATA[i*32 +: 32] = prd[i];
        end
    end

    typedef struct {
        int cyc;
        logic err;
        logic [31:0] rd;
        logic [NS-1:0] sel;
        logic [31:0] pa;
        logic [31:0] pw;
        logic pwr;
    } exp_t;
    exp_t q[$];

    logic pend = 1'b0;
    logic [31:0] pend_rd;
    logic prev_sel = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_sel = 1'b0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("rdata", rdata, pend_rd);
                pend = 1'b0;
            end
            if (apb.PSEL != 0) begin
                if (q.size() == 0) chk("psel_no_request", 32'(apb.PSEL), 0);
                else begin
                    chk("psel", 32'(apb.PSEL), 32'(q[0].sel));
                    chk("paddr", apb.PADDR, q[0].pa);
                    chk("pwdata", apb.PWDATA, q[0].pw);
                    chk("pwrite", 32'(apb.PWRITE), 32'(q[0].pwr));
                end
            end
            chk("penable", 32'(apb.PENABLE), 32'(prev_sel && apb.PSEL != 0));
            prev_sel = apb.PSEL != 0;
            if (ready) begin
                if (q.size() == 0) chk("spurious_ready", 32'(ready), 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ready_cycle", cyc, e.cyc);
                    chk("slvErr", 32'(slvErr), 32'(e.err));
                    pend = 1'b1;
                    pend_rd = e.rd;
                end
            end
        end
    end

    logic [31:0] model_rd = '0;

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int wt, input logic err, input int lat, input logic hold);
        exp_t e;
        int n;
        logic [31:0] ab;
        ab = a;
        waits = wt;
        if (err) model_rd = '0;
        else if (!w) model_rd = prd[ab[13:12]];
        e.cyc = cyc + lat;
        e.err = err;
        e.rd = model_rd;
        e.sel = err ? '0 : NS'(1) << ab[15:12];
        e.pa = a;
        e.pw = d;
        e.pwr = w;
        q.push_back(e);
        transfer = 1'b1;
        write = w;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        addr = 32'hDEAD_BEEF;
        wdata = 32'hFFFF_0000;
        write = ~w;
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_wait", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) transfer = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        prd[0] = 32'hAAAA_0000;
        prd[1] = 32'h1111_1111;
        prd[2] = 32'h1234_5678;
        prd[3] = 32'h3333_3333;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", 32'(apb.PSEL), 0);
        chk("rst_penable", 32'(apb.PENABLE), 0);
        chk("rst_pwrite", 32'(apb.PWRITE), 0);
        chk("rst_paddr", apb.PADDR, 0);
        chk("rst_pwdata", apb.PWDATA, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ready", 32'(ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        req(1'b1, 32'h1000_1004, 32'hA5A5_0001, 0, 1'b0, 2, 1'b0);
        req(1'b0, 32'h1000_2000, 32'h0, 3, 1'b0, 5, 1'b0);
        req(1'b0, 32'h2000_0000, 32'h0, 0, 1'b1, 1, 1'b0);
        req(1'b0, 32'h1000_0010, 32'h0, 1, 1'b0, 3, 1'b1);
        req(1'b0, 32'h1000_3FFC, 32'h0, 0, 1'b0, 2, 1'b0);
        req(1'b0, 32'h1000_4000, 32'h0, 0, 1'b1, 1, 1'b0);
        req(1'b0, 32'h1000_1008, 32'h0, 0, 1'b0, 2, 1'b0);
        req(1'b1, 32'h1001_0000, 32'h0, 0, 1'b1, 1, 1'b0);
        req(1'b0, 32'h1000_1008, 32'h0, 0, 1'b0, 2, 1'b0);
        req(1'b1, 32'h1000_0020, 32'h5555_AAAA, 1, 1'b0, 3, 1'b0);

        // abort a stalled ACCESS with reset
        begin
            exp_t e;
            e.cyc = cyc + 1000;
            e.err = 1'b0;
            e.rd = '0;
            e.sel = 4'b0010;
            e.pa = 32'h1000_1000;
            e.pw = 32'h0;
            e.pwr = 1'b0;
            q.push_back(e);
        end
        waits = 1000;
        transfer = 1'b1;
        write = 1'b0;
        addr = 32'h1000_1000;
        wdata = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        transfer = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        model_rd = '0;
        @(negedge clk);
        chk("abort_psel", 32'(apb.PSEL), 0);
        chk("abort_penable", 32'(apb.PENABLE), 0);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_rdata", rdata, 0);
        @(posedge clk);
        #1;
        req(1'b0, 32'h1000_2004, 32'h0, 0, 1'b0, 2, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        req(1'b0, 32'h1000_1000, 32'h0, 1000, 1'b1, 9, 1'b0);
        req(1'b0, 32'h1000_3000, 32'h0, 7, 1'b0, 9, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/apb_master.md
# apb_master

Bus master that turns the CPU control unit's single-request memory handshake (`transfer`/`ready`) into APB3 transfers. Decodes the address onto one of `NUM_SLAVES` peripheral selects and sequences the SETUP and ACCESS phases. Returns read data and a completion strobe the multicycle controller waits on in its store/load memory states. Sits between the CPU core and the peripheral slaves (GPIO, UART, timers).

## Interface
- `NUM_SLAVES`, 4: number of peripheral selects, 1..16.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS-phase length; used only when the timeout feature is compiled in.
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `transfer` in 1: request from the CPU, held high until `ready`.
- `write` in 1: 1 = write, 0 = read; valid while `transfer` is high.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `ready` out 1: single-cycle completion strobe.
- `slvErr` out 1: completion carried an error; valid only while `ready` is high.
- `PADDR` out 32: registered.
- `PWDATA` out 32: registered.
- `PWRITE` out 1: registered.
- `PENABLE` out 1: APB enable.
- `PSEL` out NUM_SLAVES: one-hot peripheral select.
- `PRDATA` in NUM_SLAVES*32: slave *i* occupies bits [32i+31:32i].
- `PREADY` in NUM_SLAVES: per-slave ready.

## Operation
- **Address map.** A request is mapped when `addr[31:16]==16'h1000` and `addr[15:12] < NUM_SLAVES`. The selected slave index is `addr[15:12]`, so each slave gets a 4 KB window.
- **States.** The block has four states: IDLE, SETUP, ACCESS and ERROR.
- **IDLE.**
  - `transfer` is sampled only in IDLE.
  - On `transfer=1`, `addr`, `wdata` and `write` are latched into `PADDR`, `PWDATA` and `PWRITE`, and the slave index is latched.
  - Mapped request: go to SETUP.
  - Unmapped request: go to ERROR.
- **SETUP.** `PSEL[idx]=1`, `PENABLE=0`. Always goes to ACCESS.
- **ACCESS.** `PSEL[idx]=1`, `PENABLE=1`.
  - If `PREADY[idx]=1`: `ready=1` combinationally and `slvErr=0`. On a read, `rdata` is loaded from `PRDATA[idx]` at that edge. Go to IDLE.
  - Otherwise stay in ACCESS.
- **ERROR.** `ready=1`, `slvErr=1`, `rdata` loads 32'h0, `PSEL=0`. Go to IDLE.
- **Select and enable.** `PSEL` and `PENABLE` are 0 in IDLE and ERROR.
- **Held values.** `PADDR`, `PWDATA` and `PWRITE` hold their values from SETUP through ACCESS, and keep their last values while in IDLE.
- **`rdata` persistence.** `rdata` holds until the next read completion or error completion, so the CPU can consume it in the cycle after `ready`.
- **Writes.** A write completion does not change `rdata`.
- **Requester contract.** The requester deasserts `transfer` in the cycle after `ready`. If `transfer` is still high in IDLE, it is treated as a new request (back-to-back requests are legal).
- **Input changes mid-request.** Changes to `addr`, `wdata` or `write` after IDLE are ignored until the next IDLE sample.
- **Other slaves.** `PREADY` from non-selected slaves is ignored.

## Timing
- **Reset values.** While `reset` is sampled high, at the next edge: state IDLE, `PSEL=0`, `PENABLE=0`, `PWRITE=0`, `PADDR=0`, `PWDATA=0`, `rdata=0`. `ready` and `slvErr` are 0 whenever the state is IDLE.
- **Reset mid-transaction.** If `reset` is sampled in any state, the next cycle is IDLE with all selects low. No `ready` is generated for the aborted transaction.
- **Mapped latency.** `transfer` sampled in cycle 0 → SETUP in cycle 1 → ACCESS from cycle 2. `ready` appears in cycle 2+W, where W is the number of PREADY-low wait cycles.
- **Unmapped latency.** `ready` and `slvErr` appear in cycle 1.
- **Back-to-back spacing.** After `ready`, there is one IDLE cycle before the next SETUP.

## Configuration
- **`APB_MASTER_TIMEOUT_EN` defined.**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments on each ACCESS cycle with `PREADY[idx]=0`.
  - If the count equals `TIMEOUT_CYCLES-1` and `PREADY[idx]=0`, that cycle asserts `ready=1` and `slvErr=1`, `rdata` loads 32'h0, and the next state is IDLE. ACCESS therefore never exceeds `TIMEOUT_CYCLES` cycles.
  - If `PREADY` is high in the same cycle the count expires, a normal completion takes priority.
- **Not defined.** No counter; ACCESS waits indefinitely. `slvErr` arises only from unmapped addresses.

## Structure
- **Package `apb_pkg`.** Holds:
  - the `apb_state_e` enum (IDLE, SETUP, ACCESS, ERROR);
  - `APB_BASE_HI=16'h1000`;
  - the slave window size;
  - `MAX_SLAVES=16`.
- **Sub-module `apb_addr_decoder`.** Combinational; takes `addr` and outputs `mapped` plus a 4-bit index. Instantiated once inside `apb_master`; reused later by the interconnect.

## Test plan
- **Zero-wait write.** Write `addr=0x1000_1004`, `wdata=0xA5A5_0001`, `PREADY[1]=1` → cycle 1: `PSEL=4'b0010`, `PENABLE=0`, `PWRITE=1`. Cycle 2: `PENABLE=1` and `ready=1`, with `PADDR`/`PWDATA` stable. Cycle 3: IDLE, `rdata` unchanged.
- **Read with wait states.** Read `0x1000_2000` with `PREADY[2]` low for 3 ACCESS cycles and `PRDATA[2]=0x1234_5678` → `ready` in cycle 5 with `slvErr=0`. `rdata=0x1234_5678` from cycle 6 and held thereafter.
- **Unmapped access.** Request to `0x2000_0000` → no `PSEL` bit ever set. Cycle 1: `ready=1`, `slvErr=1`. `rdata=0`.
- **Back-to-back.** `transfer` held across two reads to slaves 0 and 3 → second SETUP appears 2 cycles after the first `ready`, with `PSEL=4'b1000`.
- **Reset in ACCESS.** Reset while in ACCESS with `PREADY` low → the next cycle has `PSEL=0`, `PENABLE=0`, `ready=0`. A new request afterwards completes normally.
- **Timeout (`APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`).** `PREADY` stuck low → `ready=1` and `slvErr=1` in the 8th ACCESS cycle (cycle 9), then IDLE. A variant with `PREADY` rising in the 8th ACCESS cycle → `slvErr=0`.
